// File: rtl/network_sink_pkg.sv
// network_sink_pkg: shared definitions for the network output sink.
//   - sink message opcodes and opcode field width
//   - FSM state encodings
//   - width helpers that derive the SPK index and full message widths from
//     the number of network outputs and the RUN payload width
package network_sink_pkg;

    typedef enum logic [1:0] {
        NOP     = 2'd0,
        RUN     = 2'd1,
        SPK     = 2'd2,
        NUM_OPS = 2'd3
    } snk_opcode_t;

    localparam int unsigned SNK_OPC_WIDTH = $clog2(int'(NUM_OPS));

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_EMIT_RUN  = 2'd1;
    localparam logic [1:0] ST_EMIT_SPK  = 2'd2;
    localparam logic [1:0] ST_EMIT_STEP = 2'd3;

    // A single output needs no index bits; its SPK payload is then all zero.
    function automatic int unsigned spk_width(input int unsigned num_out);
        return (num_out > 1) ? $clog2(num_out) : 0;
    endfunction

    function automatic int unsigned payload_width(input int unsigned run_w,
                                                  input int unsigned num_out);
        return (run_w > spk_width(num_out)) ? run_w : spk_width(num_out);
    endfunction

    function automatic int unsigned snk_width(input int unsigned run_w,
                                              input int unsigned num_out);
        return SNK_OPC_WIDTH + payload_width(run_w, num_out);
    endfunction

endpackage

// File: rtl/network_sink_lowest_set_idx.sv
// network_sink_lowest_set_idx: combinational priority encoder.
// Ports:
//   vec  input  [WIDTH-1:0]  vector to search
//   idx  output [IDX_W-1:0]  index of the lowest set bit (0 when none set)
//   any  output              at least one bit of vec is set
module network_sink_lowest_set_idx #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/network_sink.sv
// network_sink: serialises one network output spike vector per timestep into
// sink messages on a valid/ready stream. Empty timesteps are run-length
// compressed into RUN(n); a spiking timestep becomes SPK(idx) per set bit in
// ascending order followed by RUN(1) marking the end of that timestep.
// Ports:
//   clk        input                     system clock
//   arst       input                     asynchronous active-high reset
//   net_valid  input                     network presents a timestep vector
//   net_ready  output                    sink accepts the vector this cycle
//   net_out    input  [NET_NUM_OUT-1:0]  per-output fire bits
//   flush      input                     emit any pending RUN count
//   snk_valid  output                    message valid (registered)
//   snk_ready  input                     downstream accepts message
//   snk        output [SNK_WIDTH-1:0]    {opcode, payload, zero LSBs}
module network_sink
    import network_sink_pkg::*;
#(
    parameter int unsigned NET_NUM_OUT = 4,
    parameter int unsigned RUN_WIDTH   = 8,
    localparam int unsigned SNK_WIDTH  = snk_width(RUN_WIDTH, NET_NUM_OUT)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   net_valid,
    output logic                   net_ready,
    input  logic [NET_NUM_OUT-1:0] net_out,
    input  logic                   flush,
    output logic                   snk_valid,
    input  logic                   snk_ready,
    output logic [SNK_WIDTH-1:0]   snk
);

    localparam int unsigned SPK_W = spk_width(NET_NUM_OUT);
    localparam int unsigned IDX_W = (SPK_W > 0) ? SPK_W : 1;
    localparam int unsigned PAY_W = payload_width(RUN_WIDTH, NET_NUM_OUT);
    localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;

    logic [1:0]             state_q, state_d;
    logic [RUN_WIDTH-1:0]   run_pend_q, run_pend_d;
    logic                   flush_req_q, flush_req_d;
    logic [NET_NUM_OUT-1:0] vec_q, vec_d;
    logic                   snk_valid_q, snk_valid_d;
    logic [SNK_WIDTH-1:0]   snk_q, snk_d;

    logic [IDX_W-1:0]       idx_cur, idx_nxt;
    logic                   any_cur, any_nxt;
    logic [RUN_WIDTH-1:0]   run_inc;
    logic                   accept, retire;

    function automatic logic [SNK_WIDTH-1:0] run_msg(input logic [RUN_WIDTH-1:0] n);
        logic [SNK_WIDTH-1:0] m;
        m = '0;
        m[SNK_WIDTH-1 -: SNK_OPC_WIDTH] = RUN;
        m[PAY_W-1 -: RUN_WIDTH] = n;
        return m;
    endfunction

    function automatic logic [SNK_WIDTH-1:0] spk_msg(input logic [IDX_W-1:0] i);
        logic [SNK_WIDTH-1:0] m;
        m = '0;
        m[SNK_WIDTH-1 -: SNK_OPC_WIDTH] = SPK;
        m[PAY_W-1 -: IDX_W] = (SPK_W > 0) ? i : '0;
        return m;
    endfunction

    // idx_cur is the index currently presented; idx_nxt looks at the vector
    // as it will be after this cycle, so the next SPK can be registered.
    network_sink_lowest_set_idx #(
        .WIDTH (NET_NUM_OUT)
    ) u_enc_cur (
        .vec (vec_q),
        .idx (idx_cur),
        .any (any_cur)
    );

    network_sink_lowest_set_idx #(
        .WIDTH (NET_NUM_OUT)
    ) u_enc_nxt (
        .vec (vec_d),
        .idx (idx_nxt),
        .any (any_nxt)
    );

    assign net_ready = (state_q == ST_IDLE) && !flush_req_q && (run_pend_q != RUN_MAX);
    assign accept    = net_valid && net_ready;
    assign retire    = snk_valid_q && snk_ready;
    assign run_inc   = run_pend_q + 1'b1;
    assign snk_valid = snk_valid_q;
    assign snk       = snk_q;

    always_comb begin
        state_d     = state_q;
        run_pend_d  = run_pend_q;
        flush_req_d = flush_req_q;
        vec_d       = vec_q;
        snk_valid_d = snk_valid_q;
        snk_d       = snk_q;

        case (state_q)
            ST_IDLE: begin
                if (flush_req_q) begin
                    // Deferred flush is served before any new vector.
                    flush_req_d = 1'b0;
                    if (run_pend_q != '0) begin
                        state_d     = ST_EMIT_RUN;
                        snk_valid_d = 1'b1;
                        snk_d       = run_msg(run_pend_q);
                    end
                end else if (accept) begin
                    if (flush) begin
                        flush_req_d = 1'b1;
                    end
                    if (net_out == '0) begin
                        run_pend_d = run_inc;
                        if (run_inc == RUN_MAX) begin
                            state_d     = ST_EMIT_RUN;
                            snk_valid_d = 1'b1;
                            snk_d       = run_msg(RUN_MAX);
                        end
                    end else begin
                        vec_d       = net_out;
                        snk_valid_d = 1'b1;
                        if (run_pend_q != '0) begin
                            state_d = ST_EMIT_RUN;
                            snk_d   = run_msg(run_pend_q);
                        end else begin
                            state_d = ST_EMIT_SPK;
                            snk_d   = spk_msg(idx_nxt);
                        end
                    end
                end else if (flush && (run_pend_q != '0)) begin
                    state_d     = ST_EMIT_RUN;
                    snk_valid_d = 1'b1;
                    snk_d       = run_msg(run_pend_q);
                end
            end

            ST_EMIT_RUN: begin
                if (flush) begin
                    flush_req_d = 1'b1;
                end
                if (retire) begin
                    run_pend_d = '0;
                    if (any_cur) begin
                        state_d = ST_EMIT_SPK;
                        snk_d   = spk_msg(idx_nxt);
                    end else begin
                        state_d     = ST_IDLE;
                        snk_valid_d = 1'b0;
                        snk_d       = '0;
                    end
                end
            end

            ST_EMIT_SPK: begin
                if (flush) begin
                    flush_req_d = 1'b1;
                end
                if (retire) begin
                    vec_d = vec_q & ~(NET_NUM_OUT'(1) << idx_cur);
                    if (any_nxt) begin
                        snk_d = spk_msg(idx_nxt);
                    end else begin
                        state_d = ST_EMIT_STEP;
                        snk_d   = run_msg(RUN_WIDTH'(1));
                    end
                end
            end

            ST_EMIT_STEP: begin
                if (flush) begin
                    flush_req_d = 1'b1;
                end
                if (retire) begin
                    state_d     = ST_IDLE;
                    snk_valid_d = 1'b0;
                    snk_d       = '0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                snk_valid_d = 1'b0;
                snk_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            run_pend_q  <= '0;
            flush_req_q <= 1'b0;
            vec_q       <= '0;
            snk_valid_q <= 1'b0;
            snk_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_pend_q  <= run_pend_d;
            flush_req_q <= flush_req_d;
            vec_q       <= vec_d;
            snk_valid_q <= snk_valid_d;
            snk_q       <= snk_d;
        end
    end

endmodule

// File: doc/network_sink.md
Name: network_sink

Overview:
- Output-side counterpart of the dispatch source: consumes one network output spike vector per timestep and serialises it into sink messages over a valid/ready stream toward the host link.
- Consecutive timesteps with no output spikes are run-length compressed into a single RUN message.
- Sits between the network output port and the sink transport (UART/FIFO), mirroring the source's opcode/payload framing.

Parameters:
- RUN_WIDTH, 8, width of the RUN count payload; RUN_MAX = 2**RUN_WIDTH-1.

Ports:
- clk  input  1  system clock
- arst  input  1  reset, asynchronous, active-high
- net_valid  input  1  network has a completed timestep output
- net_ready  output  1  sink accepts the output vector this cycle
- net_out  input  NET_NUM_OUT  per-output fire bits for the timestep
- flush  input  1  request emission of any pending RUN count
- snk_valid  output  1  message valid
- snk_ready  input  1  downstream accepts message
- snk  output  SNK_WIDTH  message: opcode in MSBs, payload directly below, unused LSBs zero

Behaviour:
- Clocking: one clock; arst is asynchronous, active-high. Reset values: snk_valid=0, snk=0, net_ready=1, run_pend=0, flush_req=0, latched vector=0, state IDLE. Reset mid-emission drops all pending data.
- Handshakes: vector accepted when net_valid&&net_ready. Message retired when snk_valid&&snk_ready. snk and snk_valid are registered and held stable while snk_ready=0.
- net_ready=1 only in IDLE with flush_req=0 and no saturated count pending.
- States: IDLE, EMIT_RUN, EMIT_SPK, EMIT_STEP.
- IDLE, vector accepted, all-zero:
  - run_pend+1.
  - If the result equals RUN_MAX, go to EMIT_RUN with RUN(RUN_MAX).
- IDLE, vector accepted, nonzero:
  - Latch the vector.
  - If run_pend>0, go to EMIT_RUN with RUN(run_pend); otherwise go to EMIT_SPK.
- EMIT_RUN:
  - On retire, run_pend cleared.
  - Next state is EMIT_SPK if the latched vector is nonzero, else IDLE.
- EMIT_SPK:
  - Presents SPK(idx), where idx is the lowest set bit of the latched vector.
  - On retire, clear that bit.
  - When no bits remain, go to EMIT_STEP.
  - Indices are emitted strictly ascending.
- EMIT_STEP: presents RUN(1), meaning the spiking timestep is complete. On retire, go to IDLE.
- Latency: vector accepted in cycle N; first message has snk_valid=1 in cycle N+1. With snk_ready held high, k spikes plus pending-run messages take one cycle each, and net_ready returns the cycle after the final retire.
- Flush:
  - Honored only in IDLE with no net handshake in that cycle. If run_pend>0, go to EMIT_RUN; if run_pend=0, no message.
  - flush coincident with a vector acceptance sets flush_req. flush_req is served on the next IDLE entry, before any new vector; it then emits RUN(run_pend) if nonzero and clears flush_req.
  - flush in non-IDLE states sets flush_req.
- Width rules:
  - SPK payload = $clog2(NET_NUM_OUT) bits; a NET_NUM_OUT of 1 gives a zero-width index, and the payload is then 0.
  - RUN payload = RUN_WIDTH bits.
  - SNK_WIDTH = SNK_OPC_WIDTH + max(RUN_WIDTH, SPK index width).
  - run_pend never exceeds RUN_MAX; no wrap.
- NOP opcode is never emitted.

Decomposition:
- Package sink_config (imports network_config):
  - typedef enum snk_opcode_t {NOP=0, RUN, SPK, NUM_OPS}
  - SNK_OPC_WIDTH=$clog2(NUM_OPS)
  - SNK_SPK_WIDTH=$clog2(NET_NUM_OUT)
- Macro SNK_WIDTH added to macros.svh alongside SRC_WIDTH.
- Sub-module lowest_set_idx: combinational priority encoder with parameter WIDTH, vector in, index and any outputs. Used by EMIT_SPK.

Test Plan:
All scenarios use NET_NUM_OUT=4 and RUN_WIDTH=4.
- Reset: assert arst mid-EMIT_SPK -> snk_valid=0 and net_ready=1 immediately (asynchronous); after release, the next vector emits no stale SPK.
- Vector 4'b1010 with run_pend=0, snk_ready=1 -> SPK(1), SPK(3), RUN(1) on consecutive cycles starting N+1; net_ready low for 3 cycles.
- Three zero vectors then 4'b0001 -> RUN(3), SPK(0), RUN(1); no messages during the zero vectors.
- 15 consecutive zero vectors -> RUN(15) after the 15th; net_ready=0 until retired; run_pend=0 afterwards.
- Backpressure: snk_ready=0 for 5 cycles while SPK(1) is presented -> snk stable, no index skipped, order intact.
- Flush with run_pend=2 in IDLE -> RUN(2). Flush with run_pend=0 -> no message. Flush coincident with vector 4'b0100 (run_pend=0) -> SPK(2), RUN(1), then nothing, with flush_req cleared.
